// File: rtl/edge_period_meter_pkg.sv
// Shared types and defaults for the edge period meter.
package edge_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/edge_period_meter_if.sv
// Edge-pulse inputs and measurement results of the period meter.
interface edge_period_meter_if import edge_period_meter_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);

  logic             rise_pulse;
  logic             fall_pulse;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             edge_err;
  logic             timeout;

  modport master (
    output rise_pulse, fall_pulse, clear,
    input  period, high_time, meas_valid, edge_err, timeout
  );

  modport slave (
    input  rise_pulse, fall_pulse, clear,
    output period, high_time, meas_valid, edge_err, timeout
  );

endinterface

// File: rtl/edge_period_meter.sv
// Measures period and high time of a signal from its edge pulses; flags bad edge order and timeout.
// Latency: results one cycle after the closing rise; no backpressure, strobes are fire-and-forget.
module edge_period_meter import edge_period_meter_pkg::*; #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  edge_period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             rise, fall, both, expired;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = bus.rise_pulse;
  assign fall    = bus.fall_pulse;
  assign both    = rise & fall;
  assign expired = (cnt_q == TO_VAL) && !rise && !fall;
  // Saturate so a fall landing exactly at the limit cannot push cnt past TIMEOUT.
  assign cnt_inc = (cnt_q == TO_VAL) ? cnt_q : cnt_q + ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear || both) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
                 else if (expired) state_d = IDLE;
        LOW:     if (rise) state_d = HIGH;
                 else if (fall || expired) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_cap_d = hi_cap_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    to_d     = to_q;
    if (bus.clear) begin
      cnt_d    = '0;
      hi_cap_d = '0;
      period_d = '0;
      high_d   = '0;
      to_d     = 1'b0;
    end else if (both) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (rise) cnt_d = ONE;
        HIGH: begin
          if (rise) begin
            err_d = 1'b1;
            cnt_d = ONE;
          end else begin
            if (fall) hi_cap_d = cnt_q;
            else if (expired) to_d = 1'b1;
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_cap_q;
            mv_d     = 1'b1;
            to_d     = 1'b0;
            cnt_d    = ONE;
          end else if (fall) begin
            err_d = 1'b1;
          end else begin
            if (expired) to_d = 1'b1;
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      hi_cap_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_cap_q <= hi_cap_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = mv_q;
  assign bus.edge_err   = err_q;
  assign bus.timeout    = to_q;

endmodule
